// File: rtl/dev_info_regs.sv
`default_nettype none
// ============================================================================
//  Module      : dev_info_regs
//  Description : Device information register block. It holds read-only
//                constant words, lockable scratch words, a free-running
//                uptime counter that is read coherently as LO then HI, an
//                error-access counter and a control register. Accesses use a
//                level request with a one-cycle registered acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dev_info_regs #(
    parameter int                              DATA_WIDTH    = 32,
    parameter int                              ADDR_WIDTH    = 8,
    parameter int                              NUM_CONST     = 8,
    parameter logic [NUM_CONST*DATA_WIDTH-1:0] CONST_INIT    = '0,
    parameter int                              NUM_SCRATCH   = 4,
    parameter logic [31:0]                     BAD_ADDR_DATA = 32'hdead_beef
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  reg_req,
    input  logic                  reg_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_ack,
    output logic [DATA_WIDTH-1:0] reg_rd_data
);

    // ------------------------------------------------------------------
    // Address map. Addresses are widened by one bit so that the block
    // boundaries (which may equal 2**ADDR_WIDTH) never overflow.
    // ------------------------------------------------------------------
    localparam int AXW     = ADDR_WIDTH + 1;
    localparam int BLK_END = NUM_CONST + NUM_SCRATCH;
    localparam int UPW     = 2 * DATA_WIDTH;

    localparam logic [AXW-1:0] SCR_BASE   = AXW'(NUM_CONST);
    localparam logic [AXW-1:0] UP_LO_ADDR = AXW'(BLK_END);
    localparam logic [AXW-1:0] UP_HI_ADDR = AXW'(BLK_END + 1);
    localparam logic [AXW-1:0] ERR_ADDR   = AXW'(BLK_END + 2);
    localparam logic [AXW-1:0] CTRL_ADDR  = AXW'(BLK_END + 3);

    localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(BAD_ADDR_DATA);
    localparam logic [DATA_WIDTH-1:0] ERR_MAX  = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  req_acked;
    logic [UPW-1:0]        uptime_cnt;
    logic [DATA_WIDTH-1:0] uptime_shadow;
    logic [DATA_WIDTH-1:0] err_cnt;
    logic                  lock;
    logic [DATA_WIDTH-1:0] scratch [NUM_SCRATCH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [AXW-1:0]        addr_ext;
    logic [AXW-1:0]        scr_off;
    logic                  accept;
    logic                  is_read;
    logic                  is_write;
    logic                  is_const;
    logic                  is_scr;
    logic                  is_up_lo;
    logic                  is_up_hi;
    logic                  is_err_reg;
    logic                  is_ctrl;
    logic                  is_unmapped;
    logic                  access_err;
    logic [DATA_WIDTH-1:0] const_word;
    logic [DATA_WIDTH-1:0] scr_word;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign addr_ext = {1'b0, reg_addr};
    assign scr_off  = addr_ext - SCR_BASE;

    // A new access is taken only on the first cycle of a request level.
    assign accept   = reg_req && !req_acked;
    assign is_read  = accept && reg_rd_wr_L;
    assign is_write = accept && !reg_rd_wr_L;

    // Classify the requested address into exactly one region.
    always_comb begin
        is_const    = 1'b0;
        is_scr      = 1'b0;
        is_up_lo    = 1'b0;
        is_up_hi    = 1'b0;
        is_err_reg  = 1'b0;
        is_ctrl     = 1'b0;
        is_unmapped = 1'b0;
        if (addr_ext < SCR_BASE) begin
            is_const = 1'b1;
        end else if (addr_ext < UP_LO_ADDR) begin
            is_scr = 1'b1;
        end else if (addr_ext == UP_LO_ADDR) begin
            is_up_lo = 1'b1;
        end else if (addr_ext == UP_HI_ADDR) begin
            is_up_hi = 1'b1;
        end else if (addr_ext == ERR_ADDR) begin
            is_err_reg = 1'b1;
        end else if (addr_ext == CTRL_ADDR) begin
            is_ctrl = 1'b1;
        end else begin
            is_unmapped = 1'b1;
        end
    end

    // Select the constant word addressed by the request.
    always_comb begin
        const_word = '0;
        for (int k = 0; k < NUM_CONST; k++) begin
            if (addr_ext == AXW'(k)) begin
                const_word = CONST_INIT[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Select the scratch word addressed by the request.
    always_comb begin
        scr_word = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (scr_off == AXW'(i)) begin
                scr_word = scratch[i];
            end
        end
    end

    // Read data multiplexer; CTRL exposes only the lock bit.
    always_comb begin
        rd_mux = BAD_DATA;
        if (is_const) begin
            rd_mux = const_word;
        end else if (is_scr) begin
            rd_mux = scr_word;
        end else if (is_up_lo) begin
            rd_mux = uptime_cnt[DATA_WIDTH-1:0];
        end else if (is_up_hi) begin
            rd_mux = uptime_shadow;
        end else if (is_err_reg) begin
            rd_mux = err_cnt;
        end else if (is_ctrl) begin
            rd_mux = {{(DATA_WIDTH-1){1'b0}}, lock};
        end
    end

    // Accesses that are acknowledged but flagged in ERR_CNT. Unmapped
    // addresses are errors for both reads and writes.
    assign access_err = is_unmapped ||
                        (!reg_rd_wr_L && (is_const || (is_scr && lock) ||
                                          is_up_lo || is_up_hi || is_err_reg));

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Handshake: remember that the current request level was served and
    // return a one-cycle acknowledge with registered read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_acked   <= 1'b0;
            reg_ack     <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            if (!reg_req) begin
                req_acked <= 1'b0;
            end else if (accept) begin
                req_acked <= 1'b1;
            end
            reg_ack <= accept;
            if (is_read) begin
                reg_rd_data <= rd_mux;
            end
        end
    end

    // Free-running uptime counter; it never pauses for accesses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uptime_cnt <= '0;
        end else begin
            uptime_cnt <= uptime_cnt + UPW'(1);
        end
    end

    // Capture the upper half when the lower half is read so that a
    // following HI read matches the LO value across a carry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uptime_shadow <= '0;
        end else if (is_read && is_up_lo) begin
            uptime_shadow <= uptime_cnt[UPW-1:DATA_WIDTH];
        end
    end

    // Scratch storage, writable only while the lock bit is clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (is_write && is_scr && !lock) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (scr_off == AXW'(i)) begin
                    scratch[i] <= reg_wr_data;
                end
            end
        end
    end

    // CTRL.lock is updated by every CTRL write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock <= 1'b0;
        end else if (is_write && is_ctrl) begin
            lock <= reg_wr_data[0];
        end
    end

    // Saturating error counter; a CTRL write with clear_err set wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (is_write && is_ctrl && reg_wr_data[1]) begin
            err_cnt <= '0;
        end else if (accept && access_err && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + DATA_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dev_info_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dev_info_regs
//  Description : Directed self-checking bench for dev_info_regs, covering a
//                32-bit and a 64-bit build side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dev_info_regs;

    localparam logic [255:0] CONSTS32 = {
        32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
        32'hC0DE_0003, 32'h0001_0203, 32'hC0DE_0001, 32'hC0DE_0000
    };

    // Default map: constants 0..7, scratch 8..11, then the special words.
    localparam logic [7:0] A_SCR0  = 8'd8;
    localparam logic [7:0] A_SCR3  = 8'd11;
    localparam logic [7:0] A_UPLO  = 8'd12;
    localparam logic [7:0] A_UPHI  = 8'd13;
    localparam logic [7:0] A_ERR   = 8'd14;
    localparam logic [7:0] A_CTRL  = 8'd15;
    localparam logic [7:0] A_UNMAP = 8'd16;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        req32, rw32, ack32;
    logic [7:0]  addr32;
    logic [31:0] wd32, rd32;

    logic        req64, rw64, ack64;
    logic [7:0]  addr64;
    logic [63:0] wd64, rd64;

    int          total  = 0;
    int          passed = 0;
    int          acks;
    logic [63:0] d;

    always #5 clk = ~clk;

    dev_info_regs #(
        .DATA_WIDTH (32),
        .CONST_INIT (CONSTS32)
    ) dut32 (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_req     (req32),
        .reg_rd_wr_L (rw32),
        .reg_addr    (addr32),
        .reg_wr_data (wd32),
        .reg_ack     (ack32),
        .reg_rd_data (rd32)
    );

    dev_info_regs #(
        .DATA_WIDTH (64)
    ) dut64 (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_req     (req64),
        .reg_rd_wr_L (rw64),
        .reg_addr    (addr64),
        .reg_wr_data (wd64),
        .reg_ack     (ack64),
        .reg_rd_data (rd64)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access, started and finished on a falling edge.
    task automatic access(input bit w64, input bit rd, input logic [7:0] a,
                          input logic [63:0] wdata, output logic [63:0] rdata);
        int n;
        bit got;
        if (w64) begin
            req64 = 1'b1; rw64 = rd; addr64 = a; wd64 = wdata;
        end else begin
            req32 = 1'b1; rw32 = rd; addr32 = a; wd32 = wdata[31:0];
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk);
            #1;
            n++;
            got = w64 ? ack64 : ack32;
        end
        check($sformatf("ack_latency_a%0d_w%0d", a, w64), 128'(n), 128'd1);
        rdata = w64 ? rd64 : {32'h0, rd32};
        @(negedge clk);
        req32 = 1'b0;
        req64 = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input bit w64, input logic [7:0] a, input logic [63:0] exp, input string tag);
        logic [63:0] v;
        access(w64, 1'b1, a, 64'h0, v);
        check(tag, 128'(v), 128'(exp));
    endtask

    task automatic wr(input bit w64, input logic [7:0] a, input logic [63:0] v);
        logic [63:0] unused_rd;
        access(w64, 1'b0, a, v, unused_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        req32 = 1'b0; rw32 = 1'b1; addr32 = '0; wd32 = '0;
        req64 = 1'b0; rw64 = 1'b1; addr64 = '0; wd64 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ack", 128'(ack32), 128'd0);
        check("rst_rd_data", 128'(rd32), 128'd0);
        check("rst_req_acked", 128'(dut32.req_acked), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Constant read with the request held well past the acknowledge
        req32 = 1'b1; rw32 = 1'b1; addr32 = 8'd2;
        @(posedge clk); #1;
        check("c2_ack", 128'(ack32), 128'd1);
        check("c2_data", 128'(rd32), 128'h0001_0203);
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            acks += int'(ack32);
        end
        check("c2_no_second_ack", 128'(acks), 128'd0);
        @(negedge clk);
        req32 = 1'b0;
        @(negedge clk);

        // Constants are read-only; a write is an error
        rd_chk(0, 8'd0, 64'hC0DE_0000, "const0");
        wr(0, 8'd3, 64'hFFFF_0000);
        rd_chk(0, 8'd3, 64'hC0DE_0003, "const3_after_wr");
        rd_chk(0, A_ERR, 64'd1, "err_after_const_wr");

        // A write leaves the previous read data in place
        access(0, 1'b0, A_SCR0, 64'hA5A5_5A5A, d);
        check("wr_keeps_rd_data", 128'(d), 128'd1);
        rd_chk(0, A_SCR0, 64'hA5A5_5A5A, "scr0");
        wr(0, A_SCR3, 64'h1234_5678);
        rd_chk(0, A_SCR3, 64'h1234_5678, "scr3");

        // Clear, then lock the scratch words
        wr(0, A_CTRL, 64'd2);
        rd_chk(0, A_ERR, 64'd0, "err_cleared");
        wr(0, A_CTRL, 64'd1);
        rd_chk(0, A_CTRL, 64'd1, "ctrl_lock");
        wr(0, A_SCR0, 64'd0);
        rd_chk(0, A_SCR0, 64'hA5A5_5A5A, "scr0_locked");
        rd_chk(0, A_ERR, 64'd1, "err_locked_wr");
        wr(0, A_CTRL, 64'd3);
        rd_chk(0, A_CTRL, 64'd1, "ctrl_bit1_reads_0");
        rd_chk(0, A_ERR, 64'd0, "err_clear_with_lock");

        // Unmapped and special-word error accesses
        wr(0, A_CTRL, 64'd0);
        rd_chk(0, A_UNMAP, 64'hDEAD_BEEF, "unmapped_rd");
        rd_chk(0, A_ERR, 64'd1, "err_unmapped_rd");
        wr(0, 8'd255, 64'h1);
        wr(0, A_UPLO, 64'h1);
        wr(0, A_UPHI, 64'h1);
        wr(0, A_ERR, 64'h0);
        rd_chk(0, A_ERR, 64'd5, "err_five");
        wr(0, A_CTRL, 64'd2);
        rd_chk(0, A_ERR, 64'd0, "err_cleared2");

        // Saturation of the error counter
        force dut32.err_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut32.err_cnt;
        rd_chk(0, A_ERR, 64'hFFFF_FFFF, "err_preload");
        rd_chk(0, 8'd200, 64'hDEAD_BEEF, "unmapped_rd200");
        rd_chk(0, A_ERR, 64'hFFFF_FFFF, "err_saturated");
        wr(0, A_CTRL, 64'd2);

        // Uptime coherence across the LO->HI carry (32-bit build)
        force dut32.uptime_cnt = 64'h0000_0000_FFFF_FFFF;
        @(negedge clk);
        fork
            begin
                @(posedge clk);
                #2;
                release dut32.uptime_cnt;
            end
        join_none
        rd_chk(0, A_UPLO, 64'hFFFF_FFFF, "up32_lo");
        rd_chk(0, A_UPHI, 64'h0, "up32_hi_coherent");
        access(0, 1'b1, A_UPLO, 64'h0, d);
        rd_chk(0, A_UPHI, 64'h1, "up32_hi_carried");

        // 64-bit build
        rd_chk(1, A_UNMAP, 64'h0000_0000_DEAD_BEEF, "w64_unmapped");
        wr(1, A_SCR0, 64'h0123_4567_89AB_CDEF);
        rd_chk(1, A_SCR0, 64'h0123_4567_89AB_CDEF, "w64_scr0");
        force dut64.uptime_cnt = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        @(negedge clk);
        fork
            begin
                @(posedge clk);
                #2;
                release dut64.uptime_cnt;
            end
        join_none
        rd_chk(1, A_UPLO, 64'hFFFF_FFFF_FFFF_FFFF, "up64_lo");
        rd_chk(1, A_UPHI, 64'h0, "up64_hi_coherent");
        access(1, 1'b1, A_UPLO, 64'h0, d);
        rd_chk(1, A_UPHI, 64'h1, "up64_hi_carried");

        // Reset during the acceptance cycle
        reset_n = 1'b0;
        req32 = 1'b1; rw32 = 1'b1; addr32 = A_SCR0;
        @(posedge clk); #1;
        check("rst_mid_no_ack", 128'(ack32), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        d = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack32) begin
                acks++;
                d = {32'h0, rd32};
            end
        end
        check("rst_mid_one_ack", 128'(acks), 128'd1);
        check("rst_mid_scr0", 128'(d), 128'd0);
        @(negedge clk);
        req32 = 1'b0;
        @(negedge clk);
        rd_chk(0, A_SCR3, 64'd0, "rst_scr3");
        rd_chk(0, A_CTRL, 64'd0, "rst_lock");
        rd_chk(0, A_ERR, 64'd0, "rst_err");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
